// File: rtl/ula_despacho_if.sv
// ula_despacho_if: decoded-op handshake plus the ULA-facing bus of the issue stage.
// The stage owns the slave side; the producer of ops and the ULA sit behind the master side.
interface ula_despacho_if;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_op;
    logic [4:0]  in_rs;
    logic [4:0]  in_rt;
    logic [4:0]  in_rd;
    logic [31:0] in_rs_val;
    logic [31:0] in_rt_val;
    logic [31:0] in_imm;
    logic        in_use_imm;
    logic        flush;
    logic [31:0] ula_saida;
    logic        ula_zero;
    logic        ula_overflow;
    logic [4:0]  controle;
    logic [31:0] A;
    logic [31:0] B;
    logic        res_valid;
    logic [4:0]  res_rd;
    logic        res_wr;
    logic        res_illegal;

    modport slave (
        input  in_valid, in_op, in_rs, in_rt, in_rd, in_rs_val, in_rt_val, in_imm, in_use_imm,
               flush, ula_saida, ula_zero, ula_overflow,
        output in_ready, controle, A, B, res_valid, res_rd, res_wr, res_illegal
    );

    modport master (
        output in_valid, in_op, in_rs, in_rt, in_rd, in_rs_val, in_rt_val, in_imm, in_use_imm,
               flush, ula_saida, ula_zero, ula_overflow,
        input  in_ready, controle, A, B, res_valid, res_rd, res_wr, res_illegal
    );
endinterface

// File: rtl/ula_despacho.sv
// ula_despacho: issue stage in front of the registered-input ULA; selects and forwards operands,
// stalls one cycle on the RAW hazard of the ULA's registered output, and tags results for writeback.
module ula_despacho #(
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    ula_despacho_if.slave          bus,
    output logic [STALL_CNT_W-1:0] stall_cnt
);
    localparam logic [4:0] OP_DIV  = 5'd3;
    localparam logic [4:0] OP_NULL = 5'd30;
    localparam logic [4:0] OP_HOLD = 5'd31;

    typedef enum logic [1:0] {IDLE, ISSUED, STALL} state_t;

    state_t                 r_state;
    state_t                 w_next;
    logic [4:0]             r_controle;
    logic [31:0]            r_a;
    logic [31:0]            r_b;
    logic [4:0]             r_issue_rd;
    logic                   r_issue_wr;
    logic                   r_issue_ill;
    logic                   r_res_valid;
    logic [4:0]             r_res_rd;
    logic                   r_res_wr;
    logic                   r_res_ill;
    logic [STALL_CNT_W-1:0] r_stall;
    logic                   w_issue_valid;
    logic                   w_hazard;
    logic                   w_ready;
    logic                   w_accept;
    logic [31:0]            w_a;
    logic [31:0]            w_rt;
    logic [31:0]            w_b;
    logic                   w_illegal;
    logic                   w_bad;
    logic                   w_branch;
    logic                   w_wr;

    // Operand select: the result on res_* this cycle is newer than the regfile copy.
    always_comb begin
        w_a       = (r_res_valid && r_res_wr && r_res_rd == bus.in_rs) ? bus.ula_saida : bus.in_rs_val;
        w_rt      = (r_res_valid && r_res_wr && r_res_rd == bus.in_rt) ? bus.ula_saida : bus.in_rt_val;
        w_b       = bus.in_use_imm ? bus.in_imm : w_rt;
        w_illegal = bus.in_op > 5'd14 && bus.in_op != OP_NULL;
        w_bad     = w_illegal || (bus.in_op == OP_DIV && w_b == 32'd0);
        w_branch  = bus.in_op >= 5'd8 && bus.in_op <= 5'd11;
        w_wr      = !w_bad && !w_branch && bus.in_rd != 5'd0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = bus.flush ? IDLE : w_accept ? ISSUED : w_hazard ? STALL : IDLE;
    end

    always_comb begin
        w_issue_valid = r_state == ISSUED;
        w_hazard      = bus.in_valid && w_issue_valid && r_issue_wr &&
                        (r_issue_rd == bus.in_rs || (!bus.in_use_imm && r_issue_rd == bus.in_rt));
        w_ready       = !bus.flush && !w_hazard;
        w_accept      = bus.in_valid && w_ready;
        bus.in_ready  = w_ready;
    end

    // Bad ops still occupy a slot, but as a harmless controle=30 with B=0 so the ULA never divides by 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_controle  <= OP_HOLD;
            r_a         <= '0;
            r_b         <= '0;
            r_issue_rd  <= '0;
            r_issue_wr  <= 1'b0;
            r_issue_ill <= 1'b0;
            r_res_valid <= 1'b0;
            r_res_rd    <= '0;
            r_res_wr    <= 1'b0;
            r_res_ill   <= 1'b0;
            r_stall     <= '0;
        end else begin
            r_controle <= w_accept ? (w_bad ? OP_NULL : bus.in_op) : OP_HOLD;
            if (w_accept) begin
                r_a         <= w_a;
                r_b         <= w_bad ? 32'd0 : w_b;
                r_issue_rd  <= bus.in_rd;
                r_issue_wr  <= w_wr;
                r_issue_ill <= w_bad;
            end
            r_res_valid <= w_issue_valid && !bus.flush;
            r_res_rd    <= r_issue_rd;
            r_res_wr    <= w_issue_valid && !bus.flush && r_issue_wr;
            r_res_ill   <= w_issue_valid && !bus.flush && r_issue_ill;
            if (bus.in_valid && !w_ready && !bus.flush && r_stall != '1)
                r_stall <= r_stall + 1'b1;
        end
    end

    assign bus.controle    = r_controle;
    assign bus.A           = r_a;
    assign bus.B           = r_b;
    assign bus.res_valid   = r_res_valid;
    assign bus.res_rd      = r_res_rd;
    assign bus.res_wr      = r_res_wr;
    assign bus.res_illegal = r_res_ill;
    assign stall_cnt       = r_stall;
endmodule

// File: tb/tb_ula_despacho.sv
// tb_ula_despacho: random and directed ops against an architectural register model, with a
// behavioural ULA and writeback regfile around the stage and a scoreboard on the result tags.
module tb_ula_despacho;
    typedef struct {
        logic [4:0]  rd;
        logic        wr;
        logic        ill;
        logic [31:0] res;
        logic        zero;
        logic        br;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] stall_cnt;
    logic [1:0]  stall2;
    logic [31:0] init_rf [32];
    logic [31:0] mrf [32];
    logic [31:0] wb [32];
    logic        wbv [32];
    exp_t        sb [$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          stall_m = 0;
    logic        last_wr = 1'b0;
    logic [4:0]  last_rd = 5'd0;

    ula_despacho_if bus();
    ula_despacho_if bus2();

    ula_despacho #(.STALL_CNT_W(16)) dut (.clk(clk), .rst_n(rst_n), .bus(bus), .stall_cnt(stall_cnt));
    ula_despacho #(.STALL_CNT_W(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2), .stall_cnt(stall2));

    always #5 clk = ~clk;

    function automatic logic [31:0] alu(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            5'd0:  return a + b;
            5'd1:  return a - b;
            5'd2:  return a * b;
            5'd3:  return b == 0 ? 32'd0 : a / b;
            5'd4:  return a & b;
            5'd5:  return a | b;
            5'd6:  return a ^ b;
            5'd7:  return ~(a | b);
            5'd8, 5'd9, 5'd10, 5'd11: return a - b;
            5'd12: return a << b[4:0];
            5'd13: return a >> b[4:0];
            5'd14: return {31'd0, $signed(a) < $signed(b)};
            5'd30: return b;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic brz(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            5'd8:  return a == b;
            5'd9:  return a != b;
            5'd10: return $signed(a) < $signed(b);
            5'd11: return $signed(a) >= $signed(b);
            default: return alu(op, a, b) == 32'd0;
        endcase
    endfunction

    // Behavioural ULA: registered inputs, holds its output while controle=31.
    always @(posedge clk)
        if (bus.controle != 5'd31) begin
            bus.ula_saida <= alu(bus.controle, bus.A, bus.B);
            bus.ula_zero  <= brz(bus.controle, bus.A, bus.B);
        end
    assign bus.ula_overflow = 1'b0;

    // Regfile: writeback lands at the edge ending the result cycle.
    always @(posedge clk)
        if (rst_n && bus.res_valid && bus.res_wr) begin
            wb[bus.res_rd]  <= bus.ula_saida;
            wbv[bus.res_rd] <= 1'b1;
        end
    assign bus.in_rs_val = wbv[bus.in_rs] ? wb[bus.in_rs] : init_rf[bus.in_rs];
    assign bus.in_rt_val = wbv[bus.in_rt] ? wb[bus.in_rt] : init_rf[bus.in_rt];

    assign bus2.in_valid     = bus.in_valid;
    assign bus2.in_op        = bus.in_op;
    assign bus2.in_rs        = bus.in_rs;
    assign bus2.in_rt        = bus.in_rt;
    assign bus2.in_rd        = bus.in_rd;
    assign bus2.in_rs_val    = bus.in_rs_val;
    assign bus2.in_rt_val    = bus.in_rt_val;
    assign bus2.in_imm       = bus.in_imm;
    assign bus2.in_use_imm   = bus.in_use_imm;
    assign bus2.flush        = bus.flush;
    assign bus2.ula_saida    = bus.ula_saida;
    assign bus2.ula_zero     = bus.ula_zero;
    assign bus2.ula_overflow = bus.ula_overflow;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, got, exp);
        end
    endtask

    always @(negedge clk)
        if (rst_n && bus.res_valid) begin
            n_cmp++;
            if (sb.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_res: res_valid=1 rd=%0d, required no result", bus.res_rd);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if ({bus.res_rd, bus.res_wr, bus.res_illegal} !== {e.rd, e.wr, e.ill}) begin
                    n_bad++;
                    $display("FAIL tag: got rd=%0d wr=%0d ill=%0d required rd=%0d wr=%0d ill=%0d",
                             bus.res_rd, bus.res_wr, bus.res_illegal, e.rd, e.wr, e.ill);
                end
                if (!e.ill) begin
                    n_cmp++;
                    if (e.br ? bus.ula_zero !== e.zero : bus.ula_saida !== e.res) begin
                        n_bad++;
                        $display("FAIL result rd=%0d: got 0x%0h zero=%0d required 0x%0h zero=%0d",
                                 e.rd, bus.ula_saida, bus.ula_zero, e.res, e.zero);
                    end
                end
            end
        end

    // Starts just after a posedge; returns just after the edge that accepts the op.
    task automatic issue(input logic [4:0] op, input logic [4:0] rs, input logic [4:0] rt,
                         input logic [4:0] rd, input logic ui, input logic [31:0] imm);
        logic [31:0] a, b;
        logic ill, bad, br, wr, hz;
        exp_t e;
        a   = mrf[rs];
        b   = ui ? imm : mrf[rt];
        ill = op > 5'd14 && op != 5'd30;
        bad = ill || (op == 5'd3 && b == 32'd0);
        br  = op >= 5'd8 && op <= 5'd11;
        wr  = !bad && !br && rd != 5'd0;
        bus.in_valid = 1'b1; bus.in_op = op; bus.in_rs = rs; bus.in_rt = rt; bus.in_rd = rd;
        bus.in_use_imm = ui; bus.in_imm = imm; bus.flush = 1'b0;
        for (int n = 0; n < 4; n++) begin
            hz = last_wr && (last_rd == rs || (!ui && last_rd == rt));
            @(negedge clk);
            check("in_ready", {31'd0, bus.in_ready}, {31'd0, !hz});
            if (hz) stall_m++;
            @(posedge clk);
            #1;
            last_wr = 1'b0;
            if (!hz) begin
                e = '{rd, wr, bad, alu(op, a, b), brz(op, a, b), br};
                sb.push_back(e);
                if (wr) mrf[rd] = e.res;
                last_wr = wr;
                last_rd = rd;
                check("controle", {27'd0, bus.controle}, bad ? 32'd30 : {27'd0, op});
                if (!bad) check("A", bus.A, a);
                check("B", bus.B, bad ? 32'd0 : b);
                break;
            end
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        bus.in_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1 last_wr = 1'b0;
    endtask

    task automatic check_reset_values();
        check("rst_controle", {27'd0, bus.controle}, 32'd31);
        check("rst_A", bus.A, 32'd0);
        check("rst_B", bus.B, 32'd0);
        check("rst_res", {28'd0, bus.res_valid, bus.res_wr, bus.res_illegal, 1'b0}, 32'd0);
        check("rst_res_rd", {27'd0, bus.res_rd}, 32'd0);
        check("rst_stall_cnt", {16'd0, stall_cnt}, 32'd0);
        check("rst_stall2", {30'd0, stall2}, 32'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        bus.in_valid = 1'b0; bus.in_op = 5'd0; bus.in_rs = 5'd0; bus.in_rt = 5'd0; bus.in_rd = 5'd0;
        bus.in_imm = 32'd0; bus.in_use_imm = 1'b0; bus.flush = 1'b0;
        for (int i = 0; i < 32; i++) begin
            init_rf[i] = (i == 0) ? 32'd0 : $urandom;
            wbv[i] = 1'b0;
        end
        init_rf[10] = 32'd5; init_rf[11] = 32'd7; init_rf[12] = 32'd9; init_rf[13] = 32'd4;
        init_rf[20] = 32'd2; init_rf[21] = 32'd3; init_rf[22] = 32'd10;
        init_rf[23] = 32'h1234; init_rf[24] = 32'h1234;
        for (int i = 0; i < 32; i++) mrf[i] = init_rf[i];
        repeat (2) @(posedge clk);
        #1 check_reset_values();
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;
        // back-to-back independent ops
        issue(5'd0, 5'd10, 5'd11, 5'd1, 1'b0, 32'd0);
        issue(5'd1, 5'd12, 5'd13, 5'd2, 1'b0, 32'd0);
        // dependent pair: one stall, A forwarded
        issue(5'd0, 5'd20, 5'd21, 5'd3, 1'b0, 32'd0);
        issue(5'd4, 5'd3, 5'd0, 5'd4, 1'b1, 32'h6);
        check("stall_after_dep", {16'd0, stall_cnt}, 32'd1);
        // divide by zero, then a real divide
        issue(5'd3, 5'd22, 5'd0, 5'd5, 1'b1, 32'd0);
        issue(5'd3, 5'd22, 5'd0, 5'd5, 1'b1, 32'd3);
        // branches on equal operands
        issue(5'd8, 5'd23, 5'd24, 5'd0, 1'b0, 32'd0);
        issue(5'd9, 5'd23, 5'd24, 5'd0, 1'b0, 32'd0);
        idle(3);
        // flush during the stall of a dependent pair: first op never produces a result
        bus.in_valid = 1'b1; bus.in_op = 5'd0; bus.in_rs = 5'd10; bus.in_rt = 5'd11; bus.in_rd = 5'd6;
        bus.in_use_imm = 1'b0; bus.flush = 1'b0;
        @(negedge clk) check("flush_first_ready", {31'd0, bus.in_ready}, 32'd1);
        @(posedge clk);
        #1;
        bus.in_op = 5'd4; bus.in_rs = 5'd6; bus.in_rd = 5'd7; bus.in_use_imm = 1'b1; bus.in_imm = 32'h6;
        bus.flush = 1'b1;
        @(negedge clk) check("flush_ready", {31'd0, bus.in_ready}, 32'd0);
        @(posedge clk);
        #1 bus.flush = 1'b0;
        idle(3);
        check("flush_stall_cnt", {16'd0, stall_cnt}, stall_m);
        issue(5'd4, 5'd6, 5'd0, 5'd7, 1'b1, 32'h6);
        idle(3);
        // reset with an op in flight
        issue(5'd0, 5'd10, 5'd11, 5'd0, 1'b0, 32'd0);
        #2 rst_n = 1'b0;
        #1 check_reset_values();
        sb.delete();
        stall_m = 0;
        last_wr = 1'b0;
        @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        idle(3);
        // random stream
        for (int k = 0; k < 300; k++) begin
            logic [4:0] op;
            if ($urandom_range(0, 4) == 0) idle($urandom_range(1, 2));
            op = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(15, 31)) :
                 ($urandom_range(0, 15) == 0) ? 5'd30 : 5'($urandom_range(0, 14));
            issue(op, 5'($urandom_range(0, 15)), 5'($urandom_range(0, 15)), 5'($urandom_range(0, 7)),
                  1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom);
        end
        idle(1);
        for (int i = 0; i < 10 && sb.size() != 0; i++) @(posedge clk);
        @(negedge clk);
        check("drain", sb.size(), 32'd0);
        check("stall_cnt", {16'd0, stall_cnt}, stall_m);
        check("stall_cnt_sat2", {30'd0, stall2}, stall_m > 3 ? 32'd3 : stall_m);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
